// File: rtl/div_pkg.sv
// Shared definitions for the divider result path: the formatter FSM state
// type and the BCD digit-count derivation.
package div_pkg;

  // Formatter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Number of BCD digits needed to hold an unsigned value of w bits
  function automatic int digits_f(input int w);
    return (3 * w) / 10 + 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// One BCD digit correction for double-dabble: add 3 when the digit is 5 or
// more, so the following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Conditional +3 correction
  always_comb begin
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/div_bcd_format.sv
// Converts a divider quotient/remainder pair into sign flags plus packed BCD
// magnitudes. Both values run through double-dabble in parallel, one bit per
// clock, so a conversion takes width cycles followed by a one-cycle done.
module div_bcd_format
  import div_pkg::*;
#(
  parameter int width = 6,
  localparam int DIGITS = digits_f(width)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sign,
  input  logic [width-1:0]      quotient,
  input  logic [width-1:0]      remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  q_neg,
  output logic [4*DIGITS-1:0]   q_bcd,
  output logic                  r_neg,
  output logic [4*DIGITS-1:0]   r_bcd
);

  localparam int CW = $clog2(width + 1);
  localparam logic [CW-1:0]       CNT_LOAD = CW'(width);
  localparam logic [CW-1:0]       CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]       CNT_ZERO = {CW{1'b0}};
  localparam logic [width-1:0]    MAG_ZERO = {width{1'b0}};
  localparam logic [4*DIGITS-1:0] BCD_ZERO = {(4*DIGITS){1'b0}};

  div_state_t state_r, state_s;

  logic [CW-1:0]       cnt_r;
  logic [width-1:0]    q_mag_r, r_mag_r;
  logic                q_neg_cap_r, r_neg_cap_r;
  logic [4*DIGITS-1:0] q_acc_r, r_acc_r;
  logic [4*DIGITS-1:0] q_adj_s, r_adj_s;
  logic [4*DIGITS-1:0] q_acc_s, r_acc_s;

  logic                capture_s, step_s, last_s;
  logic                q_neg_in_s, r_neg_in_s;
  logic [width-1:0]    q_mag_in_s, r_mag_in_s;

  // Sign decode: negate only when signed mode and the operand MSB is set.
  // The most-negative value negates to itself, which read unsigned is the
  // correct magnitude 2^(width-1).
  always_comb begin
    q_neg_in_s = sign & quotient[width-1];
    r_neg_in_s = sign & remainder[width-1];
    if (q_neg_in_s) begin
      q_mag_in_s = -quotient;
    end else begin
      q_mag_in_s = quotient;
    end
    if (r_neg_in_s) begin
      r_mag_in_s = -remainder;
    end else begin
      r_mag_in_s = remainder;
    end
  end

  // Per-digit add-3 correction on both accumulators
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_add3 u_q_add3 (.din(q_acc_r[4*d +: 4]), .dout(q_adj_s[4*d +: 4]));
    bcd_add3 u_r_add3 (.din(r_acc_r[4*d +: 4]), .dout(r_adj_s[4*d +: 4]));
  end

  // Shift the corrected digits left, feeding in the next magnitude bit
  always_comb begin
    q_acc_s = {q_adj_s[4*DIGITS-2:0], q_mag_r[width-1]};
    r_acc_s = {r_adj_s[4*DIGITS-2:0], r_mag_r[width-1]};
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and datapath strobes
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    step_s    = 1'b0;
    last_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          capture_s = 1'b1;
          state_s   = CONV;
        end else begin
          state_s   = IDLE;
        end
      end
      CONV: begin
        step_s = 1'b1;
        if (cnt_r == CNT_ONE) begin
          last_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = CONV;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Conversion datapath: capture operands, step double-dabble, publish results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= CNT_ZERO;
      q_mag_r     <= MAG_ZERO;
      r_mag_r     <= MAG_ZERO;
      q_neg_cap_r <= 1'b0;
      r_neg_cap_r <= 1'b0;
      q_acc_r     <= BCD_ZERO;
      r_acc_r     <= BCD_ZERO;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      q_bcd       <= BCD_ZERO;
      r_bcd       <= BCD_ZERO;
    end else if (capture_s) begin
      cnt_r       <= CNT_LOAD;
      q_mag_r     <= q_mag_in_s;
      r_mag_r     <= r_mag_in_s;
      q_neg_cap_r <= q_neg_in_s;
      r_neg_cap_r <= r_neg_in_s;
      q_acc_r     <= BCD_ZERO;
      r_acc_r     <= BCD_ZERO;
    end else if (step_s) begin
      cnt_r   <= cnt_r - CNT_ONE;
      q_mag_r <= {q_mag_r[width-2:0], 1'b0};
      r_mag_r <= {r_mag_r[width-2:0], 1'b0};
      q_acc_r <= q_acc_s;
      r_acc_r <= r_acc_s;
      if (last_s) begin
        q_bcd <= q_acc_s;
        r_bcd <= r_acc_s;
        q_neg <= q_neg_cap_r;
        r_neg <= r_neg_cap_r;
      end
    end
  end

  // Registered status: busy outside IDLE, done for the single DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_s != IDLE);
      done <= (state_s == DONE);
    end
  end

endmodule

// File: doc/div_bcd_format.md
DIV_BCD_FORMAT -- requirements
Module: div_bcd_format

Interface
REQ-001 SHALL have parameter: width, default 6, operand bit width, matching the upstream divider's quotient/remainder width.
REQ-002 SHALL derive localparam DIGITS = (3*width)/10 + 1, the BCD digits per result (2 at width=6).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: start  input  1  request to convert; sampled only in IDLE.
REQ-006 SHALL have port: sign  input  1  1 = treat quotient/remainder as two's complement.
REQ-007 SHALL have port: quotient  input  width  divider quotient.
REQ-008 SHALL have port: remainder  input  width  divider remainder.
REQ-009 SHALL have port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 SHALL have port: done  output  1  one-cycle pulse; results valid.
REQ-011 SHALL have port: q_neg  output  1  quotient is negative.
REQ-012 SHALL have port: q_bcd  output  4*DIGITS  quotient magnitude, packed BCD, digit 0 in bits [3:0].
REQ-013 SHALL have port: r_neg  output  1  remainder is negative.
REQ-014 SHALL have port: r_bcd  output  4*DIGITS  remainder magnitude, packed BCD.

Function
REQ-015 SHALL implement FSM states IDLE, CONV and DONE.
REQ-016 In IDLE with start=1 at edge k, SHALL capture magnitudes and sign flags, load counter=width, clear both BCD accumulators and go to CONV.
REQ-017 Magnitude SHALL be the two's-complement negation of the operand when sign=1 and the operand MSB=1; otherwise the raw operand. The neg flag SHALL be sign & MSB.
REQ-018 Most-negative operand (MSB=1, rest 0, sign=1) SHALL yield magnitude 2^(width-1) as unsigned with neg=1.
REQ-019 In CONV, each edge SHALL perform one double-dabble step on both values in parallel: add 3 to every BCD digit >=5, then shift left one bit with the magnitude MSB as input. The counter SHALL then decrement.
REQ-020 On the edge performing the final (width-th) step, i.e. edge k+width, SHALL load q_bcd, r_bcd, q_neg and r_neg, and go to DONE.
REQ-021 done SHALL equal (state==DONE), high for exactly one cycle between edges k+width and k+width+1. DONE SHALL go to IDLE unconditionally.
REQ-022 Outputs q_bcd, r_bcd, q_neg and r_neg SHALL hold their last values until the next DONE entry.
REQ-023 start while busy (CONV or DONE) SHALL be ignored, with no effect on the conversion in progress.
REQ-024 start held high continuously SHALL start a new conversion every width+2 cycles.
REQ-025 Input changes after the capture edge SHALL not affect the result.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, clear the counter and accumulators, and set busy=0, done=0, q_neg=0, r_neg=0, q_bcd=0, r_bcd=0.
REQ-027 Reset during CONV or DONE SHALL abort the conversion with no done pulse. The first start after rst_n rises SHALL be accepted normally.

Structure
REQ-028 Package div_pkg SHALL hold the FSM state typedef (IDLE/CONV/DONE) and the DIGITS derivation function, shared with the divider top.
REQ-029 A combinational sub-module bcd_add3 (4-bit in, 4-bit out, +3 if >=5) SHALL be instantiated per digit per value.

Verification (width=6)
REQ-030 sign=0, quotient=63, remainder=9, start at edge k -> done high after edge k+6; q_bcd=8'h63, r_bcd=8'h09, q_neg=0, r_neg=0.
REQ-031 sign=1, quotient=6'b111011, remainder=6'b111110 -> q_neg=1, q_bcd=8'h05, r_neg=1, r_bcd=8'h02.
REQ-032 quotient=6'b100000: with sign=1 -> q_neg=1, q_bcd=8'h32; with sign=0 -> q_neg=0, q_bcd=8'h32.
REQ-033 Convert 63/9, re-pulse start with quotient=1 during CONV -> busy stays 1, single done, q_bcd=8'h63; then start in the cycle after done is accepted.
REQ-034 rst_n low at edge k+3 of a conversion -> all outputs 0 immediately, no done. After release, sign=0, quotient=12, remainder=0 -> q_bcd=8'h12, r_bcd=8'h00.
REQ-035 start held high for 24 cycles -> done pulses exactly every 8 cycles, busy low only in the IDLE cycle between conversions.
